// File: rtl/lsq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsq_pkg
// Description : Shared types and helpers for the ring-buffer load/store
//               queue. Holds the entry layout, pointer/count width
//               derivation and the wrap-around pointer increment.
// Revision    : 1.0  initial ring-buffer release
// ============================================================================
package lsq_pkg;

    // Default build geometry of the queue.
    localparam int unsigned LSQ_DEPTH_DEF  = 16;
    localparam int unsigned LSQ_TAG_W_DEF  = 6;
    localparam int unsigned LSQ_ADDR_W_DEF = 32;
    localparam int unsigned LSQ_DATA_W_DEF = 32;

    // Reference entry layout at the default geometry. ls_queue_ring keeps a
    // field-for-field copy whose widths follow the instance parameters.
    typedef struct packed {
        logic                      live;
        logic [LSQ_TAG_W_DEF-1:0]  tag;
        logic                      is_store;
        logic                      addr_ok;
        logic [LSQ_ADDR_W_DEF-1:0] addr;
        logic [LSQ_DATA_W_DEF-1:0] data;
    } lsq_entry_t;

    // Pointer width: enough bits to index DEPTH entries.
    function automatic int unsigned lsq_ptr_w(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    // Count width: one extra bit so that count == DEPTH is representable.
    function automatic int unsigned lsq_cnt_w(input int unsigned depth);
        return lsq_ptr_w(depth) + 1;
    endfunction

    // Pointer increment wrapping modulo depth (depth is a power of two).
    function automatic int unsigned ptr_inc(input int unsigned ptr,
                                            input int unsigned depth);
        return (ptr + 1) & (depth - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsq_tag_cam.sv
`default_nettype none
// ============================================================================
// Module      : lsq_tag_cam
// Description : Combinational tag CAM. Compares one search tag against the
//               tag of every live entry and returns the one-hot match vector
//               plus its encoded index.
// Ports       : tag   - search tag
//               live  - per-entry live bits
//               tags  - per-entry stored tags
//               match - one-hot hit vector (all zero when no live match)
//               idx   - encoded position of the hit (0 when no hit)
// Revision    : 1.0  initial release
// ============================================================================
module lsq_tag_cam
    import lsq_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int TAG_W = 6
)(
    input  logic [TAG_W-1:0]            tag,
    input  logic [DEPTH-1:0]            live,
    input  logic [DEPTH-1:0][TAG_W-1:0] tags,
    output logic [DEPTH-1:0]            match,
    output logic [lsq_ptr_w(DEPTH)-1:0] idx
);

    localparam int IDX_W = lsq_ptr_w(DEPTH);

    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
            assign match[g] = live[g] && (tags[g] == tag);
        end
    endgenerate

    // Live tags are unique, so at most one bit is set and an OR-reduction
    // of the matching indices yields the encoded position.
    always_comb begin
        idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (match[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ls_queue_ring.sv
`default_nettype none
// ============================================================================
// Module      : ls_queue_ring
// Description : Circular-buffer load/store queue. Entries are enqueued in
//               program order at the tail, receive their address/data late
//               from the AGU by tag, issue from the head once resolved, and
//               can be squashed from a tagged entry to the tail on flush.
// Ports       : clock, reset            - clock, synchronous active-high reset
//               in_*                    - dispatch enqueue handshake
//               upd_*                   - AGU writeback by tag
//               head_*                  - oldest entry towards the D-cache
//               flush_valid, flush_tag  - squash tagged entry and younger
//               is_full, is_empty       - occupancy flags
// Options     : LSQ_STATS_EN adds occupancy, hwm (high-water mark) and
//               ovf_sticky (enqueue attempted while full) outputs.
// Revision    : 1.0  initial ring-buffer release
// ============================================================================
module ls_queue_ring
    import lsq_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int TAG_W  = 6,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
)(
    input  logic                        clock,
    input  logic                        reset,
    // dispatch
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [TAG_W-1:0]            in_tag,
    input  logic                        in_is_store,
    // AGU writeback
    input  logic                        upd_valid,
    input  logic [TAG_W-1:0]            upd_tag,
    input  logic [ADDR_W-1:0]           upd_addr,
    input  logic [DATA_W-1:0]           upd_data,
    // head issue
    output logic                        head_valid,
    input  logic                        head_ready,
    output logic [TAG_W-1:0]            head_tag,
    output logic                        head_is_store,
    output logic [ADDR_W-1:0]           head_addr,
    output logic [DATA_W-1:0]           head_data,
    // mispredict squash
    input  logic                        flush_valid,
    input  logic [TAG_W-1:0]            flush_tag,
`ifdef LSQ_STATS_EN
    output logic [lsq_cnt_w(DEPTH)-1:0] occupancy,
    output logic [lsq_cnt_w(DEPTH)-1:0] hwm,
    output logic                        ovf_sticky,
`endif
    output logic                        is_full,
    output logic                        is_empty
);

    localparam int PTR_W = lsq_ptr_w(DEPTH);
    localparam int CNT_W = lsq_cnt_w(DEPTH);
    localparam logic [CNT_W-1:0] c_full_cnt = CNT_W'(DEPTH);

    // Same layout as lsq_pkg::lsq_entry_t, re-declared so the field widths
    // follow this instance's parameters.
    typedef struct packed {
        logic              live;
        logic [TAG_W-1:0]  tag;
        logic              is_store;
        logic              addr_ok;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t               r_ent [DEPTH];
    logic [PTR_W-1:0]     r_head;
    logic [PTR_W-1:0]     r_tail;
    logic [CNT_W-1:0]     r_count;

    logic [DEPTH-1:0]             w_live;
    logic [DEPTH-1:0][TAG_W-1:0]  w_tags;
    logic [DEPTH-1:0]             w_upd_match;
    logic [PTR_W-1:0]             w_upd_idx;
    logic [DEPTH-1:0]             w_flush_match;
    logic [PTR_W-1:0]             w_flush_idx;
    logic [DEPTH-1:0]             w_squash;
    logic [PTR_W-1:0]             w_flush_pos;
    logic                         w_upd_hit;
    logic                         w_flush_hit;
    logic                         w_push;
    logic                         w_pop;
    entry_t                       w_head_ent;
    logic [PTR_W-1:0]             w_head_next;
    logic [PTR_W-1:0]             w_tail_next;
    logic [CNT_W-1:0]             w_count_next;

    function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
        return PTR_W'(ptr_inc(32'(p), DEPTH));
    endfunction

    // Distance of a slot from the head in program order.
    function automatic logic [PTR_W-1:0] rel_pos(input logic [PTR_W-1:0] slot,
                                                 input logic [PTR_W-1:0] base);
        return slot - base;
    endfunction

    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_flat
            assign w_live[g] = r_ent[g].live;
            assign w_tags[g] = r_ent[g].tag;
        end
    endgenerate

    lsq_tag_cam #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) u_upd_cam (
        .tag   (upd_tag),
        .live  (w_live),
        .tags  (w_tags),
        .match (w_upd_match),
        .idx   (w_upd_idx)
    );

    lsq_tag_cam #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) u_flush_cam (
        .tag   (flush_tag),
        .live  (w_live),
        .tags  (w_tags),
        .match (w_flush_match),
        .idx   (w_flush_idx)
    );

    assign w_upd_hit   = upd_valid && (|w_upd_match);
    assign w_flush_hit = flush_valid && (|w_flush_match);
    assign w_flush_pos = rel_pos(w_flush_idx, r_head);

    // Live entries always occupy positions 0..count-1 from the head, so the
    // squashed set is every live entry at or beyond the flushed position.
    // Comparing positions (not slots) keeps the full-queue case unambiguous.
    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_squash
            assign w_squash[g] = w_live[g] &&
                                 (rel_pos(PTR_W'(g), r_head) >= w_flush_pos);
        end
    endgenerate

    // Head view and handshakes.
    assign w_head_ent    = r_ent[r_head];
    assign head_valid    = w_head_ent.live && w_head_ent.addr_ok;
    assign head_tag      = w_head_ent.live ? w_head_ent.tag      : '0;
    assign head_is_store = w_head_ent.live ? w_head_ent.is_store : 1'b0;
    assign head_addr     = w_head_ent.live ? w_head_ent.addr     : '0;
    assign head_data     = w_head_ent.live ? w_head_ent.data     : '0;

    assign is_full  = (r_count == c_full_cnt);
    assign is_empty = (r_count == '0);
    // No look-ahead at a same-cycle pop: a full queue refuses input even
    // while the head drains.
    assign in_ready = !is_full && !flush_valid;

    assign w_push = in_valid && in_ready;
    assign w_pop  = head_valid && head_ready;

    // Pointer and count next-state.
    always_comb begin
        w_head_next  = r_head;
        w_tail_next  = r_tail;
        w_count_next = r_count;
        if (w_flush_hit) begin
            // Push cannot coincide: in_ready is low whenever flush_valid is.
            w_tail_next  = w_flush_idx;
            w_count_next = {1'b0, w_flush_pos};
            if (w_pop) begin
                w_head_next = inc(r_head);
                if (w_flush_pos == '0) begin
                    w_tail_next  = inc(r_head);
                    w_count_next = '0;
                end else begin
                    w_count_next = {1'b0, w_flush_pos} - CNT_W'(1);
                end
            end
        end else begin
            if (w_pop) begin
                w_head_next = inc(r_head);
            end
            if (w_push) begin
                w_tail_next = inc(r_tail);
            end
            case ({w_push, w_pop})
                2'b10:   w_count_next = r_count + CNT_W'(1);
                2'b01:   w_count_next = r_count - CNT_W'(1);
                default: w_count_next = r_count;
            endcase
        end
    end

    // Entry storage. Later assignments take priority: pop and flush clear
    // after an update has been applied, so a squashed entry never retains
    // a same-cycle writeback.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_ent[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_upd_hit && (PTR_W'(i) == w_upd_idx)) begin
                    r_ent[i].addr    <= upd_addr;
                    r_ent[i].addr_ok <= 1'b1;
                    if (r_ent[i].is_store) begin
                        r_ent[i].data <= upd_data;
                    end
                end
                if (w_pop && (PTR_W'(i) == r_head)) begin
                    r_ent[i].live    <= 1'b0;
                    r_ent[i].addr_ok <= 1'b0;
                end
                if (w_flush_hit && w_squash[i]) begin
                    r_ent[i].live    <= 1'b0;
                    r_ent[i].addr_ok <= 1'b0;
                end
                if (w_push && (PTR_W'(i) == r_tail)) begin
                    r_ent[i].live     <= 1'b1;
                    r_ent[i].tag      <= in_tag;
                    r_ent[i].is_store <= in_is_store;
                    r_ent[i].addr_ok  <= 1'b0;
                    r_ent[i].addr     <= '0;
                    r_ent[i].data     <= '0;
                end
            end
            r_head  <= w_head_next;
            r_tail  <= w_tail_next;
            r_count <= w_count_next;
        end
    end

`ifdef LSQ_STATS_EN
    logic [CNT_W-1:0] r_hwm;
    logic             r_ovf;

    // Tracking the next count keeps hwm >= occupancy on every cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_hwm <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (w_count_next > r_hwm) begin
                r_hwm <= w_count_next;
            end
            if (in_valid && is_full) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign occupancy  = r_count;
    assign hwm        = r_hwm;
    assign ovf_sticky = r_ovf;
`endif

endmodule
`default_nettype wire

// File: doc/ls_queue_ring.md
Name: ls_queue_ring

Overview:
- Parametrised circular-buffer load/store queue; successor to the shift-register LS queue.
- Holds memory ops in program order with per-entry tag, type, address and data.
- Accepts late address/data writeback from AGU by tag, issues the oldest ready op to memory, and squashes a tagged entry plus all younger entries on mispredict flush.
- Sits between dispatch (enqueue), AGU (update) and the D-cache port (head issue).

Parameters:
DEPTH, 16, number of entries; power of two, >=2
TAG_W, 6, width of instruction tag (ROB index); tags unique among live entries
ADDR_W, 32, memory address width
DATA_W, 32, store data width

Ports:
clock  in  1  single clock, all state on rising edge
reset  in  1  synchronous, active-high; clears queue
in_valid  in  1  dispatch offers an entry
in_ready  out  1  queue can accept this cycle
in_tag  in  TAG_W  tag of offered entry
in_is_store  in  1  1=store, 0=load
upd_valid  in  1  AGU writeback strobe
upd_tag  in  TAG_W  tag being updated
upd_addr  in  ADDR_W  resolved address
upd_data  in  DATA_W  store data (ignored for loads)
head_valid  out  1  head entry live and address resolved
head_ready  in  1  memory accepts head this cycle (pop)
head_tag  out  TAG_W  head tag
head_is_store  out  1  head type
head_addr  out  ADDR_W  head address
head_data  out  DATA_W  head store data
flush_valid  in  1  squash request
flush_tag  in  TAG_W  oldest tag to squash
is_full  out  1  count==DEPTH
is_empty  out  1  count==0

Behaviour:
- State: head_ptr, tail_ptr ($clog2(DEPTH) bits, wrap modulo DEPTH), count ($clog2(DEPTH)+1 bits), per-entry live, tag, is_store, addr_ok, addr, data.
- Reset: pointers=0, count=0, all live/addr_ok=0, all fields=0. Outputs: is_empty=1, is_full=0, head_valid=0, head_* =0, in_ready=1 (if flush_valid=0).
- in_ready = !is_full & !flush_valid (combinational).
- Enqueue when in_valid & in_ready: write entry at tail_ptr (live=1, addr_ok=0), tail_ptr+1, count+1; visible next cycle (1-cycle latency).
- head_valid = live[head_ptr] & addr_ok[head_ptr]; head_* driven combinationally from head entry; 0 when !live.
- Pop when head_valid & head_ready: clear live at head_ptr, head_ptr+1, count-1.
- Update when upd_valid: CAM on live tags; matching entry gets addr, data, addr_ok=1 at next edge. No match -> ignored. Update in the same cycle as that entry's enqueue is not allowed (undefined).
- Flush when flush_valid: CAM match k on live tags; clear live for k and every entry from k to tail_ptr-1 (wrapping); tail_ptr<=k; count<=(k-head_ptr) mod DEPTH. No match -> no effect.
- Simultaneous events:
  - Flush + pop, k==head_ptr: queue empty; head_ptr+1, tail_ptr=head_ptr+1, count=0.
  - Flush + pop, k!=head_ptr: count=((k-head_ptr) mod DEPTH)-1.
  - Flush + update on a squashed entry: flush wins.
  - Enqueue is blocked during flush.
  - Pop + enqueue: count unchanged.
  - Full + pop: in_ready stays 0 that cycle, because in_ready does not look ahead at pop.
- Reset mid-operation overrides all other inputs that cycle.

Optional Feature:
LSQ_STATS_EN
- Defined: adds outputs occupancy (count width, = count) and hwm (count width, high-water mark of count since reset). Adds ovf_sticky (1 bit), set when in_valid & is_full and cleared only by reset.
- Undefined: these ports and registers do not exist; core behaviour is identical.

Decomposition:
- Package lsq_pkg: lsq_entry_t struct {live, tag, is_store, addr_ok, addr, data}, PTR_W/CNT_W localparam derivation helper, ptr_inc wrap function.
- One sub-module, lsq_tag_cam: DEPTH-wide combinational compare of a tag against live tags, returning one-hot match and encoded index. Instantiated twice, for update and for flush.

Test Plan:
- Reset, then enqueue tags 1,2,3 (ld,st,ld) -> count=3; head_valid=0 until upd tag1 addr=0x100; next cycle head_addr=0x100, head_tag=1.
- Fill DEPTH=16 entries -> is_full=1, in_ready=0. Pop one with in_valid held -> accepted the cycle after pop; tail wraps to index 0.
- Enqueue tags 10..15, resolve all, flush tag 12 -> count=2, tail_ptr=head+2. Next enqueue of tag 20 lands at the old tag-12 slot, and updates to tags 13..15 are ignored.
- Flush tag equal to head while head_ready=1 -> is_empty=1 next cycle, head_ptr=tail_ptr.
- Update in the same cycle as flush of that tag, and update to an absent tag 0x3F -> no entry changes; head_valid is unaffected.
- Assert reset with 5 live entries during a simultaneous push/pop -> next cycle count=0, is_empty=1, all head_* =0. With LSQ_STATS_EN, hwm=0 and ovf_sticky=0.
